// File: rtl/reg_serializer.sv
// Parallel-to-serial transmitter: accepts a WIDTH-bit word over valid/ready and
// shifts it out one bit per enabled clock with first/last strobes.
// Optional trailing even-parity bit when REG_SERIALIZER_PARITY_EN is defined.
module reg_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             shift_en,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             ser_first,
   output logic             ser_last,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);
`ifdef REG_SERIALIZER_PARITY_EN
   localparam int LAST_IDX = WIDTH;
`else
   localparam int LAST_IDX = WIDTH - 1;
`endif
   localparam logic [CW-1:0] LAST_CNT = CW'(LAST_IDX);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_shift;
   logic [CW-1:0]    r_count;
   logic             w_head;
   logic             w_final;
   logic             w_load;
   logic             w_adv;
`ifdef REG_SERIALIZER_PARITY_EN
   logic             r_parity;
`endif

   assign w_final = (r_count == LAST_CNT);
   assign w_load  = in_valid && in_ready;
   assign w_adv   = (r_state == S_SHIFT) && shift_en;

`ifdef REG_SERIALIZER_PARITY_EN
   // The parity slot follows the data bits; by then the shift register is empty.
   assign w_head = (r_count == CW'(WIDTH)) ? r_parity
                 : (MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0]);
`else
   assign w_head = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
`endif

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path through
   // the case statement leaves a signal unassigned and infers a latch.
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      busy        = 1'b0;
      ser_valid   = 1'b0;
      ser_first   = 1'b0;
      ser_last    = 1'b0;
      ser_out     = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = rst_n;
            if (in_valid && rst_n) begin
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            busy      = 1'b1;
            ser_valid = shift_en;
            ser_out   = w_head;
            ser_first = shift_en && (r_count == '0);
            ser_last  = shift_en && w_final;
            // The final-bit cycle doubles as the accept window for the next word.
            if (shift_en && w_final) begin
               in_ready = rst_n;
               if (!in_valid) begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift  <= '0;
         r_count  <= '0;
`ifdef REG_SERIALIZER_PARITY_EN
         r_parity <= 1'b0;
`endif
      end else if (w_load) begin
         r_shift  <= in_data;
         r_count  <= '0;
`ifdef REG_SERIALIZER_PARITY_EN
         r_parity <= ^in_data;
`endif
      end else if (w_adv) begin
         if (MSB_FIRST) begin
            r_shift <= {r_shift[WIDTH-2:0], 1'b0};
         end else begin
            r_shift <= {1'b0, r_shift[WIDTH-1:1]};
         end
         r_count <= w_final ? '0 : r_count + CW'(1);
      end
   end

endmodule

// File: tb/tb_reg_serializer.sv
// Self-checking bench for reg_serializer: one MSB-first and one LSB-first
// instance share stimulus; a per-instance scoreboard queue holds expected bits.
module tb_reg_serializer;

   localparam int W = 8;
`ifdef REG_SERIALIZER_PARITY_EN
   localparam int FLEN = W + 1;
`else
   localparam int FLEN = W;
`endif

   typedef struct packed {
      logic d;
      logic first;
      logic last;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         shift_en;

   logic in_ready_m, ser_out_m, ser_valid_m, ser_first_m, ser_last_m, busy_m;
   logic in_ready_l, ser_out_l, ser_valid_l, ser_first_l, ser_last_l, busy_l;

   exp_t q_msb[$];
   exp_t q_lsb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   reg_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_m),
      .in_data(in_data), .shift_en(shift_en), .ser_out(ser_out_m),
      .ser_valid(ser_valid_m), .ser_first(ser_first_m), .ser_last(ser_last_m),
      .busy(busy_m)
   );

   reg_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_l),
      .in_data(in_data), .shift_en(shift_en), .ser_out(ser_out_l),
      .ser_valid(ser_valid_l), .ser_first(ser_first_l), .ser_last(ser_last_l),
      .busy(busy_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t mk_bit(input logic [W-1:0] w, input int i, input bit msb);
      exp_t e;
      if (i == W) e.d = ^w;
      else        e.d = msb ? w[W-1-i] : w[i];
      e.first = (i == 0);
      e.last  = (i == FLEN - 1);
      return e;
   endfunction

   // Monitor: compare each valid serial bit against the scoreboard, then
   // record any accept happening this cycle.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         q_msb.delete();
         q_lsb.delete();
      end else begin
         if (ser_valid_m) begin
            if (q_msb.size() == 0) begin
               check("m_unexpected_bit", 1, 0);
            end else begin
               e = q_msb.pop_front();
               check("m_ser_out", ser_out_m, e.d);
               check("m_ser_first", ser_first_m, e.first);
               check("m_ser_last", ser_last_m, e.last);
               check("m_in_ready", in_ready_m, e.last);
            end
         end
         if (ser_valid_l) begin
            if (q_lsb.size() == 0) begin
               check("l_unexpected_bit", 1, 0);
            end else begin
               e = q_lsb.pop_front();
               check("l_ser_out", ser_out_l, e.d);
               check("l_ser_first", ser_first_l, e.first);
               check("l_ser_last", ser_last_l, e.last);
               check("l_in_ready", in_ready_l, e.last);
            end
         end
         if (in_valid && in_ready_m) begin
            for (int i = 0; i < FLEN; i++) begin
               q_msb.push_back(mk_bit(in_data, i, 1'b1));
               q_lsb.push_back(mk_bit(in_data, i, 1'b0));
            end
         end
      end
   end

   task automatic send_word(input logic [W-1:0] w);
      int n;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = w;
      n = 0;
      @(negedge clk);
      while (!in_ready_m && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("accept_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = W'($urandom);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while ((busy_m || busy_l || q_msb.size() != 0 || q_lsb.size() != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("idle_reached", (n < 300), 1);
      check("idle_ready", {in_ready_m, in_ready_l, ser_valid_m, ser_valid_l}, 4'b1100);
   endtask

   initial begin
      int n;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      shift_en = 1'b1;

      // Reset, then idle.
      repeat (3) begin
         @(negedge clk);
         check("rst_outputs",
               {in_ready_m, ser_out_m, ser_valid_m, ser_first_m, ser_last_m, busy_m,
                in_ready_l, ser_out_l, ser_valid_l, ser_first_l, ser_last_l, busy_l}, 0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", {in_ready_m, in_ready_l}, 2'b11);
      repeat (3) begin
         @(negedge clk);
         check("idle_quiet", {ser_valid_m, ser_valid_l, busy_m, busy_l}, 0);
      end

      // Single frame.
      send_word(8'hA5);
      wait_idle();

      // Stall after bit 2.
      send_word(8'h3C);
      repeat (3) @(posedge clk);
      #1 shift_en = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("stall_valid", {ser_valid_m, ser_valid_l, busy_m, busy_l}, 4'b0011);
         check("stall_hold_m", ser_out_m, q_msb[0].d);
         check("stall_hold_l", ser_out_l, q_lsb[0].d);
         check("stall_no_ready", {in_ready_m, in_ready_l}, 0);
         @(posedge clk);
      end
      #1 shift_en = 1'b1;
      wait_idle();

      // Back-to-back frames with in_valid held.
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = 8'hFF;
      @(negedge clk);
      check("b2b_ready0", in_ready_m, 1);
      @(posedge clk); #1;
      in_data = 8'h01;
      n = 0;
      @(negedge clk);
      n++;
      check("b2b_valid_a", ser_valid_m, 1);
      while (!in_ready_m && n < 50) begin
         @(negedge clk);
         n++;
         check("b2b_valid_a", ser_valid_m, 1);
      end
      check("b2b_ready_cycle", n, FLEN);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < FLEN; i++) begin
         @(negedge clk);
         check("b2b_valid_b", {ser_valid_m, ser_valid_l}, 2'b11);
         if (i != 0) @(posedge clk);
         else        @(posedge clk);
         #1;
      end
      @(negedge clk);
      check("b2b_end_idle", {ser_valid_m, busy_m, in_ready_m}, 3'b001);
      wait_idle();

      // LSB-first single-bit word, then reset mid-frame.
      send_word(8'h01);
      wait_idle();
      send_word(8'h96);
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_clear",
            {in_ready_m, ser_out_m, ser_valid_m, ser_first_m, ser_last_m, busy_m,
             in_ready_l, ser_out_l, ser_valid_l, ser_first_l, ser_last_l, busy_l}, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_abort", {in_ready_m, in_ready_l, busy_m, busy_l}, 4'b1100);

      // Parity-relevant words (plain frames in the default build).
      send_word(8'h07);
      wait_idle();
      send_word(8'h03);
      wait_idle();

      // Random words under random shift_en stalls.
      for (int k = 0; k < 6; k++) begin
         send_word(W'($urandom));
         n = 0;
         while (n < 100) begin
            @(posedge clk); #1;
            shift_en = 1'($urandom_range(0, 1));
            if (!busy_m) break;
            n++;
         end
         shift_en = 1'b1;
         wait_idle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/reg_serializer.md
Name: reg_serializer

Overview:
- Parallel-to-serial transmitter for register words.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per enabled clock, with frame strobes.
- Sits downstream of the team's parallel Reg block and pairs with a serial-in/parallel-out capture register at the far end of the link.

Parameters:
- WIDTH, 8: data word width in bits; legal range 2..32.
- MSB_FIRST, 1: 1 transmits in_data[WIDTH-1] first; 0 transmits in_data[0] first.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset; assertion is asynchronous, release is synchronous to clk.
- in_valid  input  1  in_data holds a word to transmit.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  parallel word.
- shift_en  input  1  advance enable for the serial stream; low stalls the frame.
- ser_out  output  1  serial data bit.
- ser_valid  output  1  ser_out carries a valid bit this cycle.
- ser_first  output  1  first bit of a frame, qualified by ser_valid.
- ser_last  output  1  final bit of a frame, qualified by ser_valid.
- busy  output  1  frame in progress (SHIFT state).

Behaviour:
- Reset values (rst_n low):
  - state = IDLE.
  - shift register, bit counter, ser_out, ser_valid, ser_first, ser_last, busy all = 0.
  - in_ready = 0 while rst_n is low.
- State machine: two states, IDLE and SHIFT. The bit counter has width $clog2(WIDTH+1).
- IDLE:
  - in_ready = 1; busy = 0; ser_valid = 0.
  - Accept occurs when in_valid && in_ready. On accept, register in_data into the shift register, clear the counter, and go to SHIFT.
- SHIFT:
  - busy = 1.
  - Combinational outputs:
    - ser_valid = shift_en.
    - ser_out = current head bit (MSB or LSB per MSB_FIRST).
    - ser_first = shift_en && counter == 0.
    - ser_last = shift_en && final bit.
  - Each cycle with shift_en = 1: shift the register by one toward the head and increment the counter.
  - Each cycle with shift_en = 0: hold the register and counter. ser_out still shows the held bit but ser_valid = 0.
  - With shift_en held high, the frame occupies exactly WIDTH consecutive cycles.
- Latency: the first bit is on ser_out/ser_valid in the cycle after accept. in_data is sampled only at accept, so later changes to in_data do not affect the frame.
- End of frame and back-to-back frames:
  - in_ready = 1 in SHIFT only on the final-bit cycle with shift_en = 1.
  - If in_valid is also 1 in that cycle, the next word loads and SHIFT continues with counter = 0. There is no idle gap between frames.
  - Otherwise the block returns to IDLE.
- in_ready is 0 at all other times in SHIFT. in_valid asserted then is ignored and must be held by the source.
- rst_n asserted mid-frame: the frame is aborted immediately, all outputs return to their reset values, and no partial-frame recovery is attempted.
- WIDTH = 2 boundary: ser_first and ser_last fall on consecutive cycles and are never both high.

Optional Feature:
- Macro: REG_SERIALIZER_PARITY_EN.
- Defined:
  - The frame is WIDTH+1 bits. After the last data bit, one even-parity bit is sent, equal to the XOR of the accepted word.
  - ser_last marks the parity bit, and the back-to-back in_ready window moves to the parity cycle.
  - The counter range extends to WIDTH.
  - The parity bit obeys shift_en stalls like any data bit.
- Undefined: no parity logic is present and the frame is exactly WIDTH bits.

Test Plan:
- Reset then idle: drive rst_n low for 3 cycles, then release. Required: all outputs 0 during reset; in_ready = 1 on the first cycle after release; ser_valid stays 0 with in_valid = 0.
- Single frame, MSB_FIRST = 1, WIDTH = 8: accept 0xA5 with shift_en = 1. Required: ser_out = 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting the cycle after accept; ser_first on bit 0 only; ser_last on bit 7 only; then IDLE.
- Stall: accept 0x3C, then drop shift_en for 2 cycles after bit 2. Required: ser_valid = 0 during the stall, ser_out holds the bit-3 value, and the full sequence 0,0,1,1,1,1,0,0 completes afterwards with no bit lost.
- Back-to-back: hold in_valid with 0xFF then 0x01. Required: 16 contiguous ser_valid cycles; in_ready pulses only on the bit-7 cycle; ser_first on cycles 0 and 8.
- Mid-frame reset and LSB-first: with MSB_FIRST = 0, accept 0x01; required first bit 1, then 0s. Assert rst_n low after bit 3 of the next frame; required: outputs clear asynchronously and the block returns to IDLE with in_ready = 1 after release.
- Parity, with REG_SERIALIZER_PARITY_EN defined: accept 0x07. Required: 9-bit frame whose bit 8 = 1, with ser_last on bit 8. Accept 0x03; required parity bit = 0.
